ram_dp_be: RTL and testbench
============================

// Module: ram_dp_be
// PURPOSE
//  Parametrised simple-dual-port synchronous RAM: one write port with byte enables, one read port.
//  Next generation of the team's 8-bit x 1024 single-port RAM: configurable width and depth,
//  read-valid strobe, optional output register, selectable read-during-write mode, and a
//  hardware clear engine.
//  Used as the generic buffer/scratch memory behind datapath and FIFO blocks.
// PARAMETERS
//  DATA_W       8     data width in bits; must be a multiple of 8
//  ADDR_W       10    address width
//  DEPTH        1024  number of words; 1 <= DEPTH <= 2**ADDR_W
//  OUT_REG      0     0: read latency 1 cycle; 1: extra output register, latency 2 cycles
//  RDW_NEW      0     same-address read+write in one cycle: 0 returns old data, 1 returns new (byte-merged) data
//  CLEAR_ON_RST 1     1: run the clear sweep automatically after reset release
// PORTS
//  clk       in   1             clock; all logic on rising edge
//  rst       in   1             asynchronous, active-high reset
//  wr_en     in   1             write request
//  wr_addr   in   ADDR_W        write address
//  wr_data   in   DATA_W        write data
//  wr_be     in   DATA_W/8      byte enables; bit i gates wr_data[8i+7:8i]
//  rd_en     in   1             read request
//  rd_addr   in   ADDR_W        read address
//  rd_data   out  DATA_W        read data, valid when rd_valid=1
//  rd_valid  out  1             one-cycle strobe aligned with rd_data
//  clr_req   in   1             pulse: zero entire array
//  busy      out  1             clear sweep in progress; ports ignored
// BEHAVIOUR
//  Reset and clocking
//  - One clock domain (clk). Reset is asynchronous and active-high (rst).
//  - On rst: rd_data=0, rd_valid=0, pipeline regs=0.
//    FSM -> CLEAR if CLEAR_ON_RST=1, otherwise READY.
//    busy=1 in CLEAR. The array itself is not reset.
//  FSM states
//  - READY: normal operation.
//  - CLEAR: counter clr_addr starts at 0 and writes 0 to one word per cycle.
//    After writing DEPTH-1 the FSM returns to READY; busy falls on that same edge.
//    A sweep takes exactly DEPTH cycles.
//  - clr_req sampled high in READY -> CLEAR next cycle. Any wr_en/rd_en in that same cycle are still served.
//  - In CLEAR: wr_en, rd_en and clr_req are ignored (no write, no rd_valid). In-flight reads still complete.
//  - rst mid-sweep aborts the sweep. A new sweep then restarts from 0 if CLEAR_ON_RST=1.
//  Write
//  - wr_en=1 in READY and wr_addr<DEPTH: bytes with wr_be[i]=1 are updated at the edge; other bytes keep their value.
//  - wr_be=0 is a legal no-op.
//  - wr_addr>=DEPTH: the write is dropped and no other word changes (no wrap-around).
//  Read
//  - rd_en=1 in READY at edge N: rd_data/rd_valid are presented after edge N+1+OUT_REG.
//  - rd_valid is high for 1 cycle per accepted read. Back-to-back reads give one result per cycle.
//  - rd_addr>=DEPTH: rd_data=0, rd_valid still asserted.
//  - rd_en=0: rd_data holds its last value and rd_valid=0.
//  - Same address read and write in one cycle:
//    RDW_NEW=0 -> pre-write word;
//    RDW_NEW=1 -> merged word (new bytes where wr_be=1, old bytes elsewhere).
// TESTING
//  1. Reset, CLEAR_ON_RST=1, DEPTH=16 -> busy=1 for exactly 16 cycles; reads of all addresses then return 0.
//  2. Write 0xA5 @3 with be=1, read @3 -> rd_data=0xA5 one cycle later (OUT_REG=0), or two (OUT_REG=1), with a single rd_valid pulse.
//  3. DATA_W=16: write 0x1234 be=11, then 0xFF00 be=10 @5 -> read returns 0xFF34.
//  4. Word @7=0x11; write 0x22 @7 and read @7 in the same cycle -> 0x11 (RDW_NEW=0), 0x22 (RDW_NEW=1); later read 0x22.
//  5. DEPTH=12, ADDR_W=4: write 0x55 @13 -> no word changes; read @13 -> rd_data=0 with rd_valid=1.
//  6. clr_req, rst asserted at sweep cycle 5, then released -> busy re-asserts and the sweep restarts at 0;
//     wr_en during busy has no effect and rd_en during busy produces no rd_valid.

Source files
------------

// File: rtl/ram_dp_be_if.sv
// Bus bundle for ram_dp_be: write port, read port, clear control.
// The master drives requests; the slave is the RAM.
interface ram_dp_be_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  clr_req;
  logic                  busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be,
    output rd_en, rd_addr, clr_req,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be,
    input  rd_en, rd_addr, clr_req,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte enables, optional output register,
// selectable read-during-write behaviour and a hardware clear sweep.
module ram_dp_be #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 10,
  parameter int DEPTH        = 1024,
  parameter int OUT_REG      = 0,
  parameter int RDW_NEW      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input logic        clk,
  input logic        rst,
  ram_dp_be_if.slave bus
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_C =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A =
    ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_READY,
    S_CLEAR
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic                w_busy;
  logic                w_clr_last;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_wr_in;
  logic                w_rd_in;
  logic                w_wr_ok;
  logic                w_rd_ok;
  logic [DATA_W-1:0]   w_rd_word;

  logic [DATA_W-1:0]   r_rd_data1;
  logic                r_rd_valid1;

  assign w_wr_in = ({1'b0, bus.wr_addr} < DEPTH_C);
  assign w_rd_in = ({1'b0, bus.rd_addr} < DEPTH_C);
  assign w_clr_last = (r_clr_addr == LAST_A);

  assign w_wr_ok = !w_busy && bus.wr_en && w_wr_in;
  assign w_rd_ok = !w_busy && bus.rd_en;

  // State register; reset lands in the sweep when auto-clear is on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (CLEAR_ON_RST != 0) r_state <= S_CLEAR;
      else                   r_state <= S_READY;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and busy decode.
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    unique case (r_state)
      S_READY: begin
        if (bus.clr_req) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        w_busy = 1'b1;
        if (w_clr_last) w_next = S_READY;
      end
      default: w_next = S_READY;
    endcase
  end

  assign bus.busy = w_busy;

  // Sweep address: counts during the sweep, parked at 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_addr <= '0;
    end else if (w_busy && !w_clr_last) begin
      r_clr_addr <= r_clr_addr + ADDR_W'(1);
    end else begin
      r_clr_addr <= '0;
    end
  end

  // Array write: sweep zeroes one word, else byte-gated port write.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_clr_addr] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wr_be[i])
          r_mem[bus.wr_addr][8*i +: 8] <=
            bus.wr_data[8*i +: 8];
      end
    end
  end

  // Read word with optional forwarding of same-cycle write bytes.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_in) w_rd_word = r_mem[bus.rd_addr];
    if ((RDW_NEW != 0) && w_wr_ok &&
        (bus.wr_addr == bus.rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wr_be[i])
          w_rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
      end
    end
  end

  // First read stage; data holds when no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data1  <= '0;
      r_rd_valid1 <= 1'b0;
    end else begin
      r_rd_valid1 <= w_rd_ok;
      if (w_rd_ok) r_rd_data1 <= w_rd_word;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] r_rd_data2;
    logic              r_rd_valid2;

    // Optional output stage, same hold rule as stage one.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rd_data2  <= '0;
        r_rd_valid2 <= 1'b0;
      end else begin
        r_rd_valid2 <= r_rd_valid1;
        if (r_rd_valid1) r_rd_data2 <= r_rd_data1;
      end
    end

    assign bus.rd_data  = r_rd_data2;
    assign bus.rd_valid = r_rd_valid2;
  end else begin : g_noreg
    assign bus.rd_data  = r_rd_data1;
    assign bus.rd_valid = r_rd_valid1;
  end

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench: two RAM instances (registered/new-data and unregistered/old-data)
// share one stimulus stream and are checked against an array model.
module tb_ram_dp_be;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEP = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [1:0]    wr_be = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          clr_req = 1'b0;

  ram_dp_be_if #(.DATA_W(DW), .ADDR_W(AW)) ifa ();
  ram_dp_be_if #(.DATA_W(DW), .ADDR_W(AW)) ifb ();

  assign ifa.wr_en = wr_en;   assign ifb.wr_en = wr_en;
  assign ifa.wr_addr = wr_addr; assign ifb.wr_addr = wr_addr;
  assign ifa.wr_data = wr_data; assign ifb.wr_data = wr_data;
  assign ifa.wr_be = wr_be;   assign ifb.wr_be = wr_be;
  assign ifa.rd_en = rd_en;   assign ifb.rd_en = rd_en;
  assign ifa.rd_addr = rd_addr; assign ifb.rd_addr = rd_addr;
  assign ifa.clr_req = clr_req; assign ifb.clr_req = clr_req;

  ram_dp_be #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP),
    .OUT_REG(1), .RDW_NEW(1), .CLEAR_ON_RST(1)
  ) u_a (.clk(clk), .rst(rst), .bus(ifa));

  ram_dp_be #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP),
    .OUT_REG(0), .RDW_NEW(0), .CLEAR_ON_RST(1)
  ) u_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    logic [DW-1:0] d;
    time           t;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  logic [DW-1:0] mem_m [DEP];
  int busy_left = 0;
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: pop expected reads and check value and arrival time.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.rd_valid) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = qa.pop_front();
          chk("a_rd_data", ifa.rd_data, e.d);
          chk("a_latency", 32'($time), 32'(e.t + 15));
          last_a = e.d;
        end
      end else begin
        chk("a_hold", ifa.rd_data, last_a);
      end
      if (ifb.rd_valid) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = qb.pop_front();
          chk("b_rd_data", ifb.rd_data, e.d);
          chk("b_latency", 32'($time), 32'(e.t + 5));
          last_b = e.d;
        end
      end else begin
        chk("b_hold", ifb.rd_data, last_b);
      end
    end
  end

  task automatic zero_model();
    for (int i = 0; i < DEP; i++) mem_m[i] = '0;
  endtask

  // Starts and ends on a negedge; model applied at the posedge.
  task automatic step(input logic we, input int wa,
                      input logic [DW-1:0] wd,
                      input logic [1:0] be, input logic re,
                      input int ra, input logic clr);
    logic [DW-1:0] o, n;
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    wr_be = be; rd_en = re; rd_addr = AW'(ra);
    clr_req = clr;
    chk("busy_a", ifa.busy, busy_left > 0);
    chk("busy_b", ifb.busy, busy_left > 0);
    @(posedge clk);
    if (busy_left > 0) begin
      busy_left--;
    end else begin
      o = (ra < DEP) ? mem_m[ra] : '0;
      n = o;
      if (we && wa < DEP && wa == ra) begin
        if (be[0]) n[7:0] = wd[7:0];
        if (be[1]) n[15:8] = wd[15:8];
      end
      if (re) begin
        qa.push_back('{d: n, t: $time});
        qb.push_back('{d: o, t: $time});
      end
      if (we && wa < DEP) begin
        if (be[0]) mem_m[wa][7:0] = wd[7:0];
        if (be[1]) mem_m[wa][15:8] = wd[15:8];
      end
      if (clr) begin
        busy_left = DEP;
        zero_model();
      end
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    #1;
    qa.delete(); qb.delete();
    last_a = '0; last_b = '0;
    chk("rst_valid_a", ifa.rd_valid, 0);
    chk("rst_valid_b", ifb.rd_valid, 0);
    chk("rst_data_a", ifa.rd_data, 0);
    chk("rst_data_b", ifb.rd_data, 0);
    chk("rst_busy_a", ifa.busy, 1);
    chk("rst_busy_b", ifb.busy, 1);
    repeat (hold) @(negedge clk);
    rst = 1'b0;
    busy_left = DEP;
    zero_model();
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d,
                    input logic [1:0] be);
    step(1, a, d, be, 0, 0, 0);
  endtask

  task automatic rd(input int a);
    step(0, 0, '0, 2'b00, 1, a, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 2'b00, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset(2);
    idle(DEP + 1);
    for (int a = 0; a < 16; a++) rd(a);
    idle(3);

    wr(3, 16'h00A5, 2'b01);
    rd(3);
    idle(3);

    wr(5, 16'h1234, 2'b11);
    wr(5, 16'hFF00, 2'b10);
    rd(5);
    wr(5, 16'hBEEF, 2'b00);
    rd(5);
    idle(3);

    wr(7, 16'h0011, 2'b11);
    step(1, 7, 16'h0022, 2'b11, 1, 7, 0);
    rd(7);
    step(1, 7, 16'hAB00, 2'b10, 1, 7, 0);
    idle(3);

    wr(13, 16'h0055, 2'b11);
    rd(13);
    for (int a = 0; a < DEP; a++) rd(a);
    for (int i = 0; i < 8; i++) rd(i);
    for (int a = 0; a < DEP; a++) wr(a, 16'(a * 16'h1111 + 1), 2'b11);

    step(1, 2, 16'h7777, 2'b11, 1, 2, 1);
    for (int i = 0; i < 4; i++)
      step(1, i, 16'hDEAD, 2'b11, 1, i, 1);
    do_reset(1);
    for (int i = 0; i < DEP + 2; i++)
      step(1, i % DEP, 16'hCAFE, 2'b11, 1, i % DEP, 1);
    idle(DEP);
    for (int a = 0; a < DEP; a++) rd(a);
    idle(3);

    for (int i = 0; i < 600; i++) begin
      int wa, ra;
      wa = $urandom_range(0, 15);
      ra = ($urandom_range(0, 3) == 0) ? wa
                                       : $urandom_range(0, 15);
      step($urandom_range(0, 1) == 1, wa, 16'($urandom),
           2'($urandom_range(0, 3)),
           $urandom_range(0, 2) != 0, ra,
           $urandom_range(0, 149) == 0);
    end

    idle(DEP + 4);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
